mlp_neuron_mac: RTL and testbench

//  Sequencing multiply-accumulate stage directly downstream of the per-perceptron weight memory.
//  On start it walks addresses 0..N_INPUTS-1, reads one weight and one input activation per cycle,

---
 rtl/mlp_pkg.sv | 19 +
 rtl/mlp_sat_relu.sv | 57 +++++
 rtl/mlp_neuron_mac.sv | 131 +++++++++++++
 tb/tb_mlp_neuron_mac.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP layer stages: default fixed-point geometry,
// neuron sequencer state encoding and saturation limits.
package mlp_pkg;

    localparam int MLP_ADDR_WIDTH = 6;
    localparam int MLP_DATA_WIDTH = 16;
    localparam int MLP_FRAC_BITS  = 8;

    localparam logic signed [MLP_DATA_WIDTH-1:0] Q_MAX = 16'sh7FFF;
    localparam logic signed [MLP_DATA_WIDTH-1:0] Q_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FINAL = 2'd2,
        ST_HOLD  = 2'd3
    } mlp_state_e;

endpackage

// File: rtl/mlp_sat_relu.sv
// Combinational output stage: adds the Q-format bias to a wide accumulator,
// rescales by FRAC_BITS, saturates to DATA_WIDTH and optionally applies ReLU.
module mlp_sat_relu
    import mlp_pkg::*;
#(
    parameter int DATA_WIDTH = MLP_DATA_WIDTH,
    parameter int FRAC_BITS  = MLP_FRAC_BITS,
    parameter int ACC_WIDTH  = 2*MLP_DATA_WIDTH+MLP_ADDR_WIDTH,
    parameter bit RELU_EN    = 1'b1
) (
    input  logic signed [ACC_WIDTH-1:0]  acc,
    input  logic        [DATA_WIDTH-1:0] bias,
    output logic        [DATA_WIDTH-1:0] res_data,
    output logic                         res_sat
);

    // One guard bit so the bias addition can never wrap.
    localparam int SW = ACC_WIDTH + 1;

    logic signed [SW-1:0] acc_ext_s;
    logic signed [SW-1:0] bias_ext_s;
    logic signed [SW-1:0] sum_s;
    logic signed [SW-1:0] res_s;
    logic signed [SW-1:0] max_ext_s;
    logic signed [SW-1:0] min_ext_s;

    assign acc_ext_s  = {acc[ACC_WIDTH-1], acc};
    assign bias_ext_s = {{(SW-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias};
    assign sum_s      = acc_ext_s + (bias_ext_s <<< FRAC_BITS);
    assign res_s      = sum_s >>> FRAC_BITS;
    assign max_ext_s  = {{(SW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    assign min_ext_s  = {{(SW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    // Saturate first, then ReLU, so a clipped negative still ends up as a clean zero.
    always_comb begin
        res_data = {DATA_WIDTH{1'b0}};
        res_sat  = 1'b0;
        if (res_s > max_ext_s) begin
            res_data = max_ext_s[DATA_WIDTH-1:0];
            res_sat  = 1'b1;
        end else if (res_s < min_ext_s) begin
            res_data = min_ext_s[DATA_WIDTH-1:0];
            res_sat  = 1'b1;
        end else begin
            res_data = res_s[DATA_WIDTH-1:0];
            res_sat  = 1'b0;
        end
        if (RELU_EN && res_data[DATA_WIDTH-1]) begin
            res_data = {DATA_WIDTH{1'b0}};
            res_sat  = 1'b0;
        end else begin
            res_data = res_data;
            res_sat  = res_sat;
        end
    end

endmodule

// File: rtl/mlp_neuron_mac.sv
// Single-neuron MAC sequencer: walks the weight/activation address space once per
// start, accumulates signed products and hands the scaled result downstream.
module mlp_neuron_mac
    import mlp_pkg::*;
#(
    parameter int ADDR_WIDTH = MLP_ADDR_WIDTH,
    parameter int DATA_WIDTH = MLP_DATA_WIDTH,
    parameter int FRAC_BITS  = MLP_FRAC_BITS,
    parameter int N_INPUTS   = 64,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+ADDR_WIDTH,
    parameter bit RELU_EN    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] bias,
    output logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] w_rd_data,
    input  logic [DATA_WIDTH-1:0] x_rd_data,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sat,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N_INPUTS - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    mlp_state_e                   state_r;
    mlp_state_e                   state_nxt_s;
    logic [ADDR_WIDTH-1:0]        addr_r;
    logic signed [ACC_WIDTH-1:0]  acc_r;
    logic [DATA_WIDTH-1:0]        bias_r;
    logic [DATA_WIDTH-1:0]        out_data_r;
    logic                         out_sat_r;
    logic                         out_valid_r;
    logic                         busy_r;
    logic signed [2*DATA_WIDTH-1:0] product_s;
    logic signed [ACC_WIDTH-1:0]  prod_ext_s;
    logic [DATA_WIDTH-1:0]        sat_data_s;
    logic                         sat_flag_s;

    assign product_s  = signed'(w_rd_data) * signed'(x_rd_data);
    assign prod_ext_s = {{(ACC_WIDTH-2*DATA_WIDTH){product_s[2*DATA_WIDTH-1]}}, product_s};

    mlp_sat_relu #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS),
        .ACC_WIDTH  (ACC_WIDTH),
        .RELU_EN    (RELU_EN)
    ) u_sat_relu (
        .acc      (acc_r),
        .bias     (bias_r),
        .res_data (sat_data_s),
        .res_sat  (sat_flag_s)
    );

    // Next-state logic for the evaluation sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nxt_s = ST_RUN;
                else       state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (addr_r == LAST_ADDR) state_nxt_s = ST_FINAL;
                else                     state_nxt_s = ST_RUN;
            end
            ST_FINAL: state_nxt_s = ST_HOLD;
            ST_HOLD: begin
                if (out_ready) state_nxt_s = ST_IDLE;
                else           state_nxt_s = ST_HOLD;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, address counter, accumulator and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            addr_r      <= {ADDR_WIDTH{1'b0}};
            acc_r       <= {ACC_WIDTH{1'b0}};
            bias_r      <= {DATA_WIDTH{1'b0}};
            out_data_r  <= {DATA_WIDTH{1'b0}};
            out_sat_r   <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    addr_r <= {ADDR_WIDTH{1'b0}};
                    if (start) begin
                        bias_r <= bias;
                        acc_r  <= {ACC_WIDTH{1'b0}};
                    end
                end
                ST_RUN: begin
                    acc_r <= acc_r + prod_ext_s;
                    // Return to 0 on the last product so FINAL already shows address 0.
                    if (addr_r == LAST_ADDR) addr_r <= {ADDR_WIDTH{1'b0}};
                    else                     addr_r <= addr_r + ADDR_ONE;
                end
                ST_FINAL: begin
                    addr_r      <= {ADDR_WIDTH{1'b0}};
                    out_data_r  <= sat_data_s;
                    out_sat_r   <= sat_flag_s;
                    out_valid_r <= 1'b1;
                end
                ST_HOLD: begin
                    if (out_ready) out_valid_r <= 1'b0;
                end
                default: begin
                    addr_r      <= {ADDR_WIDTH{1'b0}};
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign addr      = addr_r;
    assign busy      = busy_r;
    assign out_data  = out_data_r;
    assign out_sat   = out_sat_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_mlp_neuron_mac.sv
// Self-checking bench for mlp_neuron_mac with N_INPUTS=4; a ReLU and a linear instance
// share the stimulus, and expected results queue up in a scoreboard until handshake.
module tb_mlp_neuron_mac;

    localparam int NI = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] bias = 16'h0000;
    logic        out_ready = 1'b1;

    logic [5:0]  addr_r1, addr_r0;
    logic [15:0] w_r1, x_r1, w_r0, x_r0;
    logic        busy_r1, busy_r0;
    logic [15:0] data_r1, data_r0;
    logic        sat_r1, sat_r0;
    logic        valid_r1, valid_r0;

    logic [15:0] w_mem [0:63];
    logic [15:0] x_mem [0:63];

    logic [16:0] exp_q1 [$];
    logic [16:0] exp_q0 [$];

    int errors = 0;
    int checks = 0;
    bit addr_busy_bad = 1'b0;

    always #5 clk = ~clk;

    assign w_r1 = w_mem[addr_r1];
    assign x_r1 = x_mem[addr_r1];
    assign w_r0 = w_mem[addr_r0];
    assign x_r0 = x_mem[addr_r0];

    mlp_neuron_mac #(.ADDR_WIDTH(6), .DATA_WIDTH(16), .FRAC_BITS(8), .N_INPUTS(NI), .RELU_EN(1'b1)) dut_relu (
        .clk(clk), .rst_n(rst_n), .start(start), .bias(bias), .addr(addr_r1),
        .w_rd_data(w_r1), .x_rd_data(x_r1), .busy(busy_r1), .out_data(data_r1),
        .out_sat(sat_r1), .out_valid(valid_r1), .out_ready(out_ready)
    );

    mlp_neuron_mac #(.ADDR_WIDTH(6), .DATA_WIDTH(16), .FRAC_BITS(8), .N_INPUTS(NI), .RELU_EN(1'b0)) dut_lin (
        .clk(clk), .rst_n(rst_n), .start(start), .bias(bias), .addr(addr_r0),
        .w_rd_data(w_r0), .x_rd_data(x_r0), .busy(busy_r0), .out_data(data_r0),
        .out_sat(sat_r0), .out_valid(valid_r0), .out_ready(out_ready)
    );

    // Address must never leave 0 unless the sequencer reports busy.
    always @(negedge clk) begin
        if (rst_n && (addr_r1 != 6'd0) && !busy_r1) addr_busy_bad <= 1'b1;
    end

    // Reference neuron: {sat, data} for the current memories and a given bias.
    function automatic logic [16:0] model(input logic [15:0] b, input bit relu);
        longint acc;
        longint d;
        logic   s;
        logic [15:0] dv;
        acc = 0;
        for (int i = 0; i < NI; i++)
            acc += longint'($signed(w_mem[i])) * longint'($signed(x_mem[i]));
        acc = acc + longint'($signed(b)) * 256;
        d = acc >>> 8;
        s = 1'b0;
        if (d > 32767) begin d = 32767; s = 1'b1; end
        else if (d < -32768) begin d = -32768; s = 1'b1; end
        if (relu && d < 0) begin d = 0; s = 1'b0; end
        dv = d[15:0];
        return {s, dv};
    endfunction

    task automatic fill(input logic [15:0] w, input logic [15:0] x);
        for (int i = 0; i < 64; i++) begin
            w_mem[i] = w;
            x_mem[i] = x;
        end
    endtask

    task automatic push_exp(input logic [15:0] b);
        exp_q1.push_back(model(b, 1'b1));
        exp_q0.push_back(model(b, 1'b0));
    endtask

    task automatic pulse_start(input logic [15:0] b);
        @(posedge clk); #1;
        bias  = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!valid_r1 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #13;
        checks++;
        if ({addr_r1, busy_r1, data_r1, sat_r1, valid_r1} !== 25'd0 ||
            {addr_r0, busy_r0, data_r0, sat_r0, valid_r0} !== 25'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h/%h required 0", {addr_r1, busy_r1, data_r1, sat_r1, valid_r1},
                     {addr_r0, busy_r0, data_r0, sat_r0, valid_r0});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int n;
        logic [16:0] e1, e0;
        out_ready = 1'b1;
        fill(16'h0100, 16'h0100);
        push_exp(16'h0000);
        pulse_start(16'h0000);
        wait_valid(n);
        checks++;
        if (n !== NI + 1) begin
            errors++;
            $display("FAIL basic_latency: got %0d cycles required %0d", n, NI + 1);
        end
        e1 = exp_q1.pop_front();
        e0 = exp_q0.pop_front();
        checks++;
        if ({sat_r1, data_r1} !== e1 || {sat_r0, data_r0} !== e0 || e1 !== 17'h00400) begin
            errors++;
            $display("FAIL basic_result: got %h/%h required %h/%h", {sat_r1, data_r1}, {sat_r0, data_r0}, e1, e0);
        end
        @(posedge clk); #1;
        checks++;
        if (valid_r1 !== 1'b0 || busy_r1 !== 1'b0 || addr_r1 !== 6'd0) begin
            errors++;
            $display("FAIL basic_handshake: valid=%b busy=%b addr=%0d required 0 0 0", valid_r1, busy_r1, addr_r1);
        end
    endtask

    task automatic test_negative_and_random;
        int n;
        logic [16:0] e1, e0;
        logic [15:0] b;
        for (int t = 0; t < 7; t++) begin
            if (t == 0) begin
                fill(16'hFF00, 16'h0100);
                b = 16'h0080;
            end else begin
                for (int i = 0; i < NI; i++) begin
                    w_mem[i] = 16'($urandom_range(0, 16'hFFFF));
                    x_mem[i] = 16'($urandom_range(0, 16'h03FF)) - 16'h0200;
                end
                b = 16'($urandom_range(0, 16'hFFFF));
            end
            push_exp(b);
            pulse_start(b);
            wait_valid(n);
            e1 = exp_q1.pop_front();
            e0 = exp_q0.pop_front();
            checks++;
            if ({sat_r1, data_r1} !== e1 || {sat_r0, data_r0} !== e0 ||
                (t == 0 && (e1 !== 17'h00000 || e0 !== 17'h0FC80))) begin
                errors++;
                $display("FAIL neg_rand[%0d]: got %h/%h required %h/%h", t, {sat_r1, data_r1}, {sat_r0, data_r0}, e1, e0);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturation;
        int n;
        logic [16:0] e1, e0;
        fill(16'h7FFF, 16'h7FFF);
        push_exp(16'h7FFF);
        pulse_start(16'h7FFF);
        wait_valid(n);
        e1 = exp_q1.pop_front();
        e0 = exp_q0.pop_front();
        checks++;
        if ({sat_r1, data_r1} !== e1 || {sat_r0, data_r0} !== e0 || e0 !== 17'h17FFF) begin
            errors++;
            $display("FAIL sat_max: got %h/%h required %h/%h", {sat_r1, data_r1}, {sat_r0, data_r0}, e1, e0);
        end
        @(posedge clk); #1;
        fill(16'h8000, 16'h7FFF);
        push_exp(16'h0000);
        pulse_start(16'h0000);
        wait_valid(n);
        e1 = exp_q1.pop_front();
        e0 = exp_q0.pop_front();
        checks++;
        if ({sat_r1, data_r1} !== e1 || {sat_r0, data_r0} !== e0 || e0 !== 17'h18000 || e1 !== 17'h00000) begin
            errors++;
            $display("FAIL sat_min: got %h/%h required %h/%h", {sat_r1, data_r1}, {sat_r0, data_r0}, e1, e0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_hold;
        int n;
        logic [16:0] held, e1;
        int bad;
        fill(16'h0100, 16'h0200);
        out_ready = 1'b0;
        push_exp(16'h0100);
        pulse_start(16'h0100);
        wait_valid(n);
        held = {sat_r1, data_r1};
        fill(16'h1234, 16'h0777);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            start = (i == 3);
            if ({sat_r1, data_r1} !== held || valid_r1 !== 1'b1 || busy_r1 !== 1'b1) bad++;
        end
        start = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_stable: %0d bad cycles required 0", bad);
        end
        out_ready = 1'b1;
        e1 = exp_q1.pop_front();
        void'(exp_q0.pop_front());
        checks++;
        if (held !== e1 || e1 !== 17'h00900) begin
            errors++;
            $display("FAIL hold_result: got %h required %h", held, e1);
        end
        @(posedge clk); #1;
        checks++;
        if (valid_r1 !== 1'b0 || busy_r1 !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: valid=%b busy=%b required 0 0", valid_r1, busy_r1);
        end
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (valid_r1 !== 1'b0 || busy_r1 !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_start_ignored: %0d active cycles required 0", bad);
        end
    endtask

    task automatic test_reset_mid_run;
        int n;
        int bad;
        logic [16:0] e1;
        fill(16'h0100, 16'h0100);
        pulse_start(16'h0000);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({addr_r1, busy_r1, data_r1, sat_r1, valid_r1} !== 25'd0) begin
            errors++;
            $display("FAIL reset_mid: got %h required 0", {addr_r1, busy_r1, data_r1, sat_r1, valid_r1});
        end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (valid_r1 !== 1'b0 || busy_r1 !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_no_partial: %0d active cycles required 0", bad);
        end
        push_exp(16'h0000);
        pulse_start(16'h0000);
        wait_valid(n);
        e1 = exp_q1.pop_front();
        void'(exp_q0.pop_front());
        checks++;
        if ({sat_r1, data_r1} !== e1 || e1 !== 17'h00400) begin
            errors++;
            $display("FAIL reset_rerun: got %h required %h", {sat_r1, data_r1}, e1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int n;
        logic [16:0] e1, e0;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NI; i++) begin
                w_mem[i] = 16'($urandom_range(0, 16'h0FFF)) - 16'h0800;
                x_mem[i] = 16'($urandom_range(0, 16'h0FFF)) - 16'h0800;
            end
            push_exp(16'h0040 * 16'(k));
            bias  = 16'h0040 * 16'(k);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            wait_valid(n);
            e1 = exp_q1.pop_front();
            e0 = exp_q0.pop_front();
            checks++;
            if ({sat_r1, data_r1} !== e1 || {sat_r0, data_r0} !== e0 || n !== NI + 1) begin
                errors++;
                $display("FAIL b2b[%0d]: got %h/%h lat %0d required %h/%h lat %0d", k,
                         {sat_r1, data_r1}, {sat_r0, data_r0}, n, e1, e0, NI + 1);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_addr_trace;
        logic [5:0] exp_addr [0:6];
        int bad;
        exp_addr[0] = 6'd0; exp_addr[1] = 6'd1; exp_addr[2] = 6'd2; exp_addr[3] = 6'd3;
        exp_addr[4] = 6'd0; exp_addr[5] = 6'd0; exp_addr[6] = 6'd0;
        out_ready = 1'b1;
        push_exp(16'h0000);
        @(posedge clk); #1;
        start = 1'b1;
        bad = 0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (addr_r1 !== exp_addr[i]) begin
                bad++;
                $display("FAIL addr_trace[%0d]: got %0d required %0d", i, addr_r1, exp_addr[i]);
            end
        end
        void'(exp_q1.pop_front());
        void'(exp_q0.pop_front());
        checks++;
        if (bad != 0) errors++;
        checks++;
        if (addr_busy_bad !== 1'b0) begin
            errors++;
            $display("FAIL addr_busy: addr nonzero while busy low, flag=%b required 0", addr_busy_bad);
        end
    endtask

    initial begin
        fill(16'h0000, 16'h0000);
        test_reset();
        test_basic();
        test_negative_and_random();
        test_saturation();
        test_hold();
        test_reset_mid_run();
        test_back_to_back();
        test_addr_trace();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
